prog_clock_divider: RTL and testbench

Parametrised, runtime-programmable clock divider producing a divided clock-enable waveform and a single-cycle tick from one system clock. It generalises the fixed 2^25 divider: counter width, reset divisor and output mode are configurable, and the divisor can be reloaded glitch-free at period boundaries. It sits between the board clock and slow logic such as display scanning, debouncing and LED blinking, one instance per required rate.

---
 rtl/prog_clock_divider.sv | 136 +++++++++++++
 tb/tb_prog_clock_divider.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// prog_clock_divider
//
// Runtime-programmable clock divider. From the system clock it derives a
// divided waveform (clockOut) and a one-cycle tick once per period. The
// divisor can be reprogrammed at any time; a new value is held pending and
// only takes over at the next period boundary, so no period is ever cut
// short or stretched.
//
// Parameters
//   WIDTH        counter / divisor width in bits
//   DEFAULT_DIV  divisor active after reset (0 = stopped)
//
// Ports
//   clockIn   in   system clock, everything on the rising edge
//   reset     in   synchronous active-high reset, overrides all inputs
//   enable    in   advance the period counter on this edge
//   mode      in   0: square wave on clockOut, 1: clockOut mirrors tick
//   load      in   capture divisor into the pending register
//   divisor   in   new divisor N (0 stops the divider)
//   clockOut  out  registered divided waveform
//   tick      out  registered one-cycle pulse, once per period
//   divBusy   out  a pending divisor is waiting for the next boundary

module prog_clock_divider #(
  parameter int unsigned          WIDTH       = 25,
  parameter logic [WIDTH-1:0]     DEFAULT_DIV = WIDTH'(2**24)
) (
  input  logic             clockIn,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] divisor,
  output logic             clockOut,
  output logic             tick,
  output logic             divBusy
);

  // High phase test for the square wave: the first ceil(N/2) counts of a
  // period are high. The sum is formed one bit wider so N = 2^WIDTH-1
  // cannot overflow.
  function automatic logic in_high_half(input logic [WIDTH-1:0] cnt,
                                        input logic [WIDTH-1:0] div);
    logic [WIDTH:0] half;
    half = ({1'b0, div} + (WIDTH+1)'(1)) >> 1;
    return (div != '0) && ({1'b0, cnt} < half);
  endfunction

  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] active_q,  active_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q,    tick_d;

  logic             stopped;
  logic             wrap;
  logic [WIDTH-1:0] last_cnt;

  assign stopped  = (active_q == '0);
  // Only evaluated when not stopped, so the underflow at 0 is never used.
  assign last_cnt = active_q - WIDTH'(1);
  assign wrap     = enable && !stopped && (count_q == last_cnt);

  always_comb begin
    count_d    = count_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;
    tick_d     = wrap;

    if (stopped) begin
      // No period is running, so there is no boundary to wait for: a
      // pending divisor takes over on this edge whether enabled or not.
      count_d   = '0;
      clk_out_d = 1'b0;
      if (pend_vld_q) begin
        active_d   = pend_q;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (enable) begin
        count_d = wrap ? '0 : count_q + WIDTH'(1);
      end

      // Period boundary: a divisor loaded on this very edge wins over an
      // older pending one and goes live without passing through pending.
      if (wrap) begin
        if (load) begin
          active_d = divisor;
        end else if (pend_vld_q) begin
          active_d = pend_q;
        end
        pend_vld_d = 1'b0;
      end

      // Waveform uses the post-edge count and divisor so a new period
      // starts with its own high phase.
      if (mode) begin
        clk_out_d = wrap;
      end else if (enable) begin
        clk_out_d = in_high_half(count_d, active_d);
      end
    end

    // Capture for a later boundary; last write before the boundary wins.
    if (load && !wrap) begin
      pend_d     = divisor;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clockIn) begin
    if (reset) begin
      count_q    <= '0;
      active_q   <= DEFAULT_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clockOut = clk_out_q;
  assign tick     = tick_q;
  assign divBusy  = pend_vld_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [7:0] divisor = 8'd0;
  logic       clockOut, tick, divBusy;

  int total = 0;
  int bad   = 0;

  // Reference state: count, active divisor, pending, outputs.
  int m_count = 0, m_act = 4, m_pend = 0;
  bit m_pv = 0, m_co = 0, m_tick = 0;

  logic [10:0] sb[$];
  logic [10:0] got;

  always #5 clk = ~clk;

  prog_clock_divider #(.WIDTH(8), .DEFAULT_DIV(8'd4)) dut (
    .clockIn (clk),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
    .load    (load),
    .divisor (divisor),
    .clockOut(clockOut),
    .tick    (tick),
    .divBusy (divBusy)
  );

  assign got = {dut.count_q, clockOut, tick, divBusy};

  task automatic model_update(input logic en, input logic md, input logic ld,
                              input int dv, input logic rs);
    bit wr;
    if (rs) begin
      m_count = 0; m_act = 4; m_pend = 0; m_pv = 0; m_co = 0; m_tick = 0;
      return;
    end
    wr = en && (m_act != 0) && (m_count == m_act - 1);
    m_tick = wr;
    if (m_act == 0) begin
      m_co = 0;
      m_count = 0;
      if (m_pv) begin m_act = m_pend; m_pv = 0; end
      if (ld) begin m_pend = dv; m_pv = 1; end
    end else begin
      if (en) m_count = wr ? 0 : m_count + 1;
      if (wr && ld) begin
        m_act = dv; m_pv = 0;
      end else begin
        if (wr && m_pv) begin m_act = m_pend; m_pv = 0; end
        if (ld) begin m_pend = dv; m_pv = 1; end
      end
      if (md) m_co = wr;
      else if (en) m_co = (m_act != 0) && (m_count < (m_act + 1) / 2);
    end
  endtask

  // Drive one edge from a negedge, update the reference, queue the expected
  // post-edge outputs, and return on the following negedge.
  task automatic step(input logic en, input logic md, input logic ld,
                      input logic [7:0] dv, input logic rs);
    enable = en; mode = md; load = ld; divisor = dv; reset = rs;
    @(posedge clk);
    model_update(en, md, ld, int'(dv), rs);
    sb.push_back({8'(m_count), m_co, m_tick, m_pv});
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 8'd0, 1);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, got, exp); end
    end
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_run i=%0d got=%h exp=%h", i, got, exp); end
      total++;
      if (tick !== ((i % 4) == 0) || clockOut !== ((i % 4) < 2)) begin
        bad++;
        $display("FAIL reset_pattern edge=%0d tick=%b clockOut=%b exp_tick=%b exp_clk=%b",
                 i, tick, clockOut, (i % 4) == 0, (i % 4) < 2);
      end
    end
  endtask

  task automatic test_odd_divisor();
    logic [10:0] exp;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL odd_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd5, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL odd_load got=%h exp=%h", got, exp); end
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL odd_sq i=%0d got=%h exp=%h", i, got, exp); end
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp || clockOut !== tick) begin
        bad++; $display("FAIL odd_pulse i=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_load_mid_period();
    logic [10:0] exp;
    int busy = 0;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd10, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL mid_load10 got=%h exp=%h", got, exp); end
    for (int i = 0; i < 40 && !(m_act == 10 && m_count == 4); i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL mid_seek i=%0d got=%h exp=%h", i, got, exp); end
    end
    total++;
    if (!(m_act == 10 && m_count == 4)) begin bad++; $display("FAIL mid_seek_timeout count=%0d required=4", m_count); end
    step(1, 0, 1, 8'd3, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL mid_load3 got=%h exp=%h", got, exp); end
    busy += divBusy;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL mid_run i=%0d got=%h exp=%h", i, got, exp); end
      busy += divBusy;
    end
    total++;
    if (busy != 5) begin bad++; $display("FAIL mid_busy_cycles got=%0d exp=5", busy); end
  endtask

  task automatic test_load_on_wrap();
    logic [10:0] exp;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL wrap_reset got=%h exp=%h", got, exp); end
    for (int i = 0; i < 10 && m_count != 3; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL wrap_seek i=%0d got=%h exp=%h", i, got, exp); end
    end
    step(1, 0, 1, 8'd6, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp || divBusy !== 1'b0 || tick !== 1'b1) begin
      bad++; $display("FAIL wrap_load got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 14; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL wrap_run i=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_double_load();
    logic [10:0] exp;
    int last = -1;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL dbl_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd7, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL dbl_load7 got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd5, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL dbl_load5 got=%h exp=%h", got, exp); end
    for (int i = 3; i <= 20; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL dbl_run i=%0d got=%h exp=%h", i, got, exp); end
      if (tick === 1'b1) begin
        if (last >= 0) begin
          total++;
          if (i - last != 5) begin bad++; $display("FAIL dbl_period got=%0d exp=5", i - last); end
        end
        last = i;
      end
    end
  endtask

  task automatic test_stop_restart();
    logic [10:0] exp;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL stop_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd0, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL stop_load0 got=%h exp=%h", got, exp); end
    for (int i = 0; i < 10 && m_act != 0; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL stop_seek i=%0d got=%h exp=%h", i, got, exp); end
    end
    for (int i = 0; i < 6; i++) begin
      step(1, i[0], 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp || got !== 11'd0) begin
        bad++; $display("FAIL stop_frozen i=%0d got=%h exp=%h", i, got, exp);
      end
    end
    step(1, 0, 1, 8'd2, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL stop_load2 got=%h exp=%h", got, exp); end
    step(1, 0, 0, 8'd0, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL stop_apply got=%h exp=%h", got, exp); end
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp || tick !== j[0]) begin
        bad++; $display("FAIL stop_restart j=%0d got=%h exp=%h", j, got, exp);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [10:0] exp;
    logic en, prev_tick, prev_co, md;
    int since = 0;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL gate_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd6, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL gate_load got=%h exp=%h", got, exp); end
    for (int i = 0; i < 10 && !(m_act == 6 && m_count == 0); i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL gate_seek i=%0d got=%h exp=%h", i, got, exp); end
    end
    prev_tick = tick;
    prev_co = clockOut;
    for (int i = 0; i < 140; i++) begin
      en = ($urandom_range(0, 3) != 0);
      md = (i >= 120) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(en, md, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL gate_run i=%0d got=%h exp=%h", i, got, exp); end
      if (en) since++;
      total++;
      if (tick === 1'b1 && (prev_tick === 1'b1 || since != 6)) begin
        bad++; $display("FAIL gate_tick i=%0d enabled_edges=%0d exp=6 prev=%b", i, since, prev_tick);
      end
      if (tick === 1'b1) since = 0;
      if (!en && !md) begin
        total++;
        if (clockOut !== prev_co) begin bad++; $display("FAIL gate_hold i=%0d got=%b exp=%b", i, clockOut, prev_co); end
      end
      prev_tick = tick;
      prev_co = clockOut;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [10:0] exp;
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_reset got=%h exp=%h", got, exp); end
    step(1, 0, 1, 8'd12, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rmid_load12 got=%h exp=%h", got, exp); end
    for (int i = 0; i < 30 && !(m_act == 12 && m_count == 6); i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp) begin bad++; $display("FAIL rmid_seek i=%0d got=%h exp=%h", i, got, exp); end
    end
    step(1, 0, 1, 8'd9, 0);
    exp = sb.pop_front(); total++;
    if (got !== exp || dut.count_q !== 8'd7 || divBusy !== 1'b1) begin
      bad++; $display("FAIL rmid_pending got=%h exp=%h", got, exp);
    end
    step(1, 0, 0, 8'd0, 1);
    exp = sb.pop_front(); total++;
    if (got !== exp || got !== 11'd0 || dut.active_q !== 8'd4) begin
      bad++; $display("FAIL rmid_cleared got=%h exp=%h", got, exp);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 8'd0, 0);
      exp = sb.pop_front(); total++;
      if (got !== exp || tick !== ((i % 4) == 0)) begin
        bad++; $display("FAIL rmid_after i=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_odd_divisor();
    test_load_mid_period();
    test_load_on_wrap();
    test_double_load();
    test_stop_restart();
    test_enable_gating();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
